// File: rtl/fix_seq_num_inserter.sv
// FIX MsgSeqNum inserter: overwrites the six-digit sequence field of eligible packets with the
// next value from a sequence FIFO. Optional build macro FIX_SEQ_CHECK_EN adds an original-field digit check.
module fix_seq_num_inserter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SEQ_WORD             = 1,
    parameter int SEQ_BYTE             = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              fix_seq_num_vld,
    input  logic [23:0]                       fix_new_seq_num,
    output logic                              rd_fix_seq_num,
    output logic [7:0]                        cksum_delta,
    output logic                              cksum_delta_vld,
    output logic                              patch_err,
    output logic [1:0]                        o_dbg_state
);

    localparam int         KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [7:0] SEQ_IDX = 8'(SEQ_WORD);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SEQ = 2'd1,
        ST_PASS     = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    // Handshake: a beat transfers on a rising edge where valid and ready are both high; valid never
    // waits on ready, data is held while valid is high and ready is low.

    state_t                            r_state;
    logic [7:0]                        r_cnt;
    logic                              r_elig;
    logic [7:0]                        r_pkt_delta;
    logic [7:0]                        r_m_delta;
    logic                              r_m_tvalid;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    r_m_tdata;
    logic [KEEP_W-1:0]                 r_m_tkeep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   r_m_tuser;
    logic                              r_m_tlast;

    logic                              w_first;
    logic [15:0]                       w_tid;
    logic                              w_tid_match;
    logic                              w_elig;
    logic                              w_seq_beat;
    logic                              w_field_ok;
    logic                              w_patch;
    logic                              w_stall;
    logic                              w_out_free;
    logic                              w_s_fire;
    logic                              w_m_fire;
    logic                              w_last_out;
    logic [7:0]                        w_sum_old;
    logic [7:0]                        w_sum_new;
    logic [7:0]                        w_beat_delta;
    logic [7:0]                        w_delta_next;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    w_patched_data;

    assign w_first     = (r_cnt == 8'd0);
    assign w_tid       = s_axis_tuser[63:48];
    assign w_tid_match = (w_tid == 16'h001F) || (w_tid == 16'h007F);
    // Eligibility comes from the live tuser on the first beat, from the latch afterwards.
    assign w_elig      = w_first ? w_tid_match : r_elig;
    assign w_seq_beat  = s_axis_tvalid && w_elig && (r_cnt == SEQ_IDX);

    always_comb begin
        logic [7:0] v_old;
        logic [7:0] v_new;
        w_patched_data = s_axis_tdata;
        w_sum_old      = 8'h00;
        w_sum_new      = 8'h00;
        for (int i = 0; i < 6; i++) begin
            v_old = s_axis_tdata[8*(SEQ_BYTE+i) +: 8];
            v_new = 8'h30 + {4'h0, fix_new_seq_num[23-4*i -: 4]};
            w_sum_old = w_sum_old + v_old;
            w_sum_new = w_sum_new + v_new;
            w_patched_data[8*(SEQ_BYTE+i) +: 8] = v_new;
        end
    end

`ifdef FIX_SEQ_CHECK_EN
    logic w_digits_ok;
    logic r_pkt_err;
    logic r_m_err;
    logic w_err_next;

    always_comb begin
        logic [7:0] v_byte;
        w_digits_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v_byte = s_axis_tdata[8*(SEQ_BYTE+i) +: 8];
            if ((v_byte < 8'h30) || (v_byte > 8'h39)) begin
                w_digits_ok = 1'b0;
            end
        end
    end

    assign w_field_ok = w_digits_ok;
    assign w_err_next = (w_first ? 1'b0 : r_pkt_err) | (w_seq_beat & ~w_digits_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_err <= 1'b0;
            r_m_err   <= 1'b0;
        end else if (w_s_fire) begin
            r_pkt_err <= w_err_next;
            r_m_err   <= w_err_next;
        end
    end

    assign patch_err = cksum_delta_vld & r_m_err;
`else
    assign w_field_ok = 1'b1;
    assign patch_err  = 1'b0;
`endif

    assign w_patch      = w_seq_beat && w_field_ok;
    // Only the beat that needs a FIFO value waits for one; all other traffic flows freely.
    assign w_stall      = w_patch && !fix_seq_num_vld;
    assign w_out_free   = m_axis_tready || !r_m_tvalid;
    assign s_axis_tready = !reset && w_out_free && !w_stall;
    assign w_s_fire     = s_axis_tvalid && s_axis_tready;
    assign w_m_fire     = r_m_tvalid && m_axis_tready;
    assign w_last_out   = w_m_fire && r_m_tlast;

    assign rd_fix_seq_num = w_s_fire && w_patch;

    assign w_beat_delta = w_sum_new - w_sum_old;
    assign w_delta_next = (w_first ? 8'h00 : r_pkt_delta) + (w_patch ? w_beat_delta : 8'h00);

    assign cksum_delta_vld = w_last_out && !reset;
    assign cksum_delta     = cksum_delta_vld ? r_m_delta : 8'h00;

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign o_dbg_state   = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_elig      <= 1'b0;
            r_pkt_delta <= 8'h00;
            r_m_delta   <= 8'h00;
            r_m_tvalid  <= 1'b0;
        end else begin
            if (w_s_fire) begin
                if (s_axis_tlast) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if (w_first) begin
                    r_elig <= w_tid_match;
                end
                r_pkt_delta <= w_delta_next;
                r_m_delta   <= w_delta_next;
            end

            if (w_s_fire) begin
                r_m_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_s_fire) begin
                r_state <= s_axis_tlast ? ST_DRAIN : ST_PASS;
            end else if (w_stall) begin
                r_state <= ST_WAIT_SEQ;
            end else begin
                case (r_state)
                    ST_WAIT_SEQ: r_state <= w_first ? ST_IDLE : ST_PASS;
                    ST_DRAIN:    if (w_m_fire) r_state <= ST_IDLE;
                    default:     r_state <= r_state;
                endcase
            end
        end
    end

    // Payload registers carry no reset; r_m_tvalid qualifies them.
    always_ff @(posedge clk) begin
        if (w_s_fire) begin
            r_m_tdata <= w_patch ? w_patched_data : s_axis_tdata;
            r_m_tkeep <= s_axis_tkeep;
            r_m_tuser <= s_axis_tuser;
            r_m_tlast <= s_axis_tlast;
        end
    end

endmodule

// File: tb/tb_fix_seq_num_inserter.sv
// Bench for fix_seq_num_inserter: table of directed packets with hand-computed fields and deltas,
// plus a mid-packet reset sequence.
`timescale 1ns/1ps
module tb_fix_seq_num_inserter;

    localparam int DW       = 256;
    localparam int UW       = 128;
    localparam int KW       = DW / 8;
    localparam int SEQ_WORD = 1;
    localparam int SEQ_BYTE = 10;
    localparam int BW       = DW + KW + UW + 1;
    localparam int NV       = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic          fix_seq_num_vld = 1'b0;
    logic [23:0]   fix_new_seq_num = '0;
    logic          rd_fix_seq_num;
    logic [7:0]    cksum_delta;
    logic          cksum_delta_vld;
    logic          patch_err;
    logic [1:0]    o_dbg_state;

    always #5 clk = ~clk;

    fix_seq_num_inserter #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .SEQ_WORD             (SEQ_WORD),
        .SEQ_BYTE             (SEQ_BYTE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .fix_seq_num_vld (fix_seq_num_vld),
        .fix_new_seq_num (fix_new_seq_num),
        .rd_fix_seq_num  (rd_fix_seq_num),
        .cksum_delta     (cksum_delta),
        .cksum_delta_vld (cksum_delta_vld),
        .patch_err       (patch_err),
        .o_dbg_state     (o_dbg_state)
    );

    typedef struct {
        logic [15:0] tid;
        int          nbeats;
        logic [47:0] field;
        logic [23:0] fifo_val;
        logic [47:0] exp_field;
        int          exp_pops;
        logic [7:0]  exp_delta;
        logic        exp_err;
        int          mode;
        int          block;
        bit          b2b;
    } vec_t;

    vec_t          vecs[NV];
    logic [BW-1:0] exp_q[$];
    logic [7:0]    exp_delta_q[$];
    logic          exp_err_q[$];
    logic [23:0]   fifo_q[$];

    int            n_checks = 0;
    int            n_fail = 0;
    int            pop_cnt = 0;
    int            exp_pops = 0;
    int            cur_beat = -1;
    int            mode = 0;
    bit            vld_block = 1'b0;
    bit            pop_pend = 1'b0;
    bit            held = 1'b0;
    logic [BW-1:0] held_beat;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Sequence FIFO model and sink backpressure; updates land 2 ns after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_pend) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pop_pend = 1'b0;
            end
            #1;
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b0;
            endcase
            fix_seq_num_vld = (fifo_q.size() > 0) && !vld_block;
            fix_new_seq_num = (fifo_q.size() > 0) ? fifo_q[0] : 24'h0;
        end
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    initial begin
        logic [BW-1:0] cur;
        forever begin
            @(negedge clk);
            cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
            if (reset) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", BW'(m_axis_tvalid), BW'(1'b1));
                    check("hold_beat", cur, held_beat);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) fail_now("extra_output_beat");
                    else check("beat", cur, exp_q.pop_front());
                end
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    check("delta_vld", BW'(cksum_delta_vld), BW'(1'b1));
                    if (exp_delta_q.size() == 0) begin
                        fail_now("unexpected_packet_end");
                    end else begin
                        check("cksum_delta", BW'(cksum_delta), BW'(exp_delta_q.pop_front()));
                        check("patch_err", BW'(patch_err), BW'(exp_err_q.pop_front()));
                    end
                end else if (m_axis_tvalid) begin
                    check("no_strobe", BW'({cksum_delta_vld, patch_err}), BW'(2'b00));
                end
                held      = m_axis_tvalid && !m_axis_tready;
                held_beat = cur;
                if (rd_fix_seq_num) begin
                    pop_cnt++;
                    pop_pend = 1'b1;
                    check("rd_timing", BW'({s_axis_tvalid, s_axis_tready, cur_beat == SEQ_WORD}),
                          BW'(3'b111));
                end
            end
        end
    end

    // Entered and left 1 ns after a rising edge.
    task automatic send_pkt(input vec_t v);
        logic [DW-1:0] d;
        logic [DW-1:0] d_exp;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        int            stall;
        stall = 0;
        if (v.exp_pops > 0) fifo_q.push_back(v.fifo_val);
        exp_pops += v.exp_pops;
        exp_delta_q.push_back(v.exp_delta);
        exp_err_q.push_back(v.exp_err);
        vld_block = (v.block > 0);
        for (int b = 0; b < v.nbeats; b++) begin
            for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
            k = $urandom;
            for (int w = 0; w < UW / 32; w++) u[32*w +: 32] = $urandom;
            u[63:48] = (b == 0) ? v.tid : 16'h001F;
            if (b == SEQ_WORD) begin
                for (int i = 0; i < 6; i++) d[8*(SEQ_BYTE+i) +: 8] = v.field[47-8*i -: 8];
            end
            d_exp = d;
            if (b == SEQ_WORD) begin
                for (int i = 0; i < 6; i++) d_exp[8*(SEQ_BYTE+i) +: 8] = v.exp_field[47-8*i -: 8];
            end
            exp_q.push_back({d_exp, k, u, (b == v.nbeats - 1)});
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tuser  = u;
            s_axis_tlast  = (b == v.nbeats - 1);
            s_axis_tvalid = 1'b1;
            cur_beat      = b;
            forever begin
                @(negedge clk);
                if (s_axis_tready) break;
                stall++;
                if (stall > 200) begin
                    fail_now("send_timeout");
                    break;
                end
                @(posedge clk);
                #1;
                if (vld_block && stall >= v.block) vld_block = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cur_beat      = -1;
        vld_block     = 1'b0;
        if (v.mode == 0) check("stall_cycles", BW'(stall), BW'(v.block));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || m_axis_tvalid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
        check("pop_count", BW'(pop_cnt), BW'(exp_pops));
    endtask

    initial begin
        //            tid       beats field     fifo       exp field pops delta  err  mode blk b2b
        vecs[0]  = '{16'h001F, 3,   "000001", 24'h000002, "000002", 1, 8'h01, 1'b0, 0, 0, 1'b0};
        vecs[1]  = '{16'h0000, 3,   "000001", 24'h000000, "000001", 0, 8'h00, 1'b0, 0, 0, 1'b0};
        vecs[2]  = '{16'h007F, 4,   "999999", 24'h000000, "000000", 1, 8'hCA, 1'b0, 0, 0, 1'b0};
        vecs[3]  = '{16'h001F, 1,   "000001", 24'h000000, "000001", 0, 8'h00, 1'b0, 0, 0, 1'b0};
        vecs[4]  = '{16'h001F, 2,   "000100", 24'h123456, "123456", 1, 8'h14, 1'b0, 0, 0, 1'b0};
        vecs[5]  = '{16'h001E, 2,   "000005", 24'h000000, "000005", 0, 8'h00, 1'b0, 0, 0, 1'b0};
        vecs[6]  = '{16'h007F, 6,   "100000", 24'h999999, "999999", 1, 8'h35, 1'b0, 0, 0, 1'b0};
        vecs[7]  = '{16'h001F, 3,   "000007", 24'h000008, "000008", 1, 8'h01, 1'b0, 0, 5, 1'b0};
        vecs[8]  = '{16'h001F, 3,   "000000", 24'h000010, "000010", 1, 8'h01, 1'b0, 1, 0, 1'b1};
        vecs[9]  = '{16'h007F, 2,   "000000", 24'h000011, "000011", 1, 8'h02, 1'b0, 1, 0, 1'b0};
        vecs[10] = '{16'h0000, 300, "000000", 24'h000000, "000000", 0, 8'h00, 1'b0, 0, 0, 1'b0};
`ifdef FIX_SEQ_CHECK_EN
        vecs[11] = '{16'h001F, 3,   "00A001", 24'h000000, "00A001", 0, 8'h00, 1'b1, 0, 0, 1'b0};
`else
        vecs[11] = '{16'h001F, 3,   "00A001", 24'h000002, "000002", 1, 8'hF0, 1'b0, 0, 0, 1'b0};
`endif

        // Reset state, with the sink ready so only reset can hold s_axis_tready low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", BW'(s_axis_tready), BW'(1'b0));
        check("rst_m_tvalid", BW'(m_axis_tvalid), BW'(1'b0));
        check("rst_rd", BW'(rd_fix_seq_num), BW'(1'b0));
        check("rst_delta", BW'({cksum_delta, cksum_delta_vld, patch_err}), BW'(10'h000));
        check("rst_state", BW'(o_dbg_state), BW'(2'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            mode = vecs[i].mode;
            send_pkt(vecs[i]);
            if (!vecs[i].b2b) drain();
        end

        // Reset with an eligible first beat stuck in the output register.
        mode = 2;
        @(posedge clk);
        #1;
        s_axis_tdata  = {8{$urandom}};
        s_axis_tkeep  = '1;
        s_axis_tuser  = '0;
        s_axis_tuser[63:48] = 16'h001F;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        cur_beat      = 0;
        @(negedge clk);
        check("abort_accept", BW'(s_axis_tready), BW'(1'b1));
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        cur_beat      = -1;
        reset         = 1'b1;
        @(negedge clk);
        check("abort_rst_tready", BW'(s_axis_tready), BW'(1'b0));
        @(posedge clk);
        @(negedge clk);
        check("abort_flush", BW'({m_axis_tvalid, o_dbg_state}), BW'(3'b000));
        @(posedge clk);
        #1;
        reset = 1'b0;
        mode  = 0;
        send_pkt(vecs[0]);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
